// File: rtl/rps_match_scorer.sv
// Match scorekeeper for the stone-paper-scissors judge: tallies round results,
// detects first-to-target or round-limit match end, and holds the result until a new match.
module rps_match_scorer #(
  parameter int WIN_TARGET  = 3,
  parameter int ROUND_LIMIT = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_match,
  input  logic       res_valid,
  output logic       res_ready,
  input  logic [7:0] res_code,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [3:0] round_cnt,
  output logic [3:0] invalid_cnt,
  output logic       match_done,
  output logic [1:0] match_winner,
  output logic       done_pulse,
  output logic [7:0] status_char
);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  localparam logic [3:0] WIN_T   = 4'(WIN_TARGET);
  localparam logic [3:0] ROUND_T = 4'(ROUND_LIMIT);

  state_t     state_reg;
  logic [3:0] p1_next;
  logic [3:0] p2_next;
  logic [3:0] round_next;
  logic [3:0] invalid_next;
  logic       end_next;
  logic [1:0] winner_next;
  logic [7:0] status_next;

  // Post-update counter values and end-of-match decision for a transfer this cycle
  always_comb begin
    p1_next      = p1_score;
    p2_next      = p2_score;
    round_next   = round_cnt;
    invalid_next = invalid_cnt;
    case (res_code)
      8'd49: begin
        p1_next    = p1_score + 4'd1;
        round_next = round_cnt + 4'd1;
      end
      8'd50: begin
        p2_next    = p2_score + 4'd1;
        round_next = round_cnt + 4'd1;
      end
      8'd0: round_next = round_cnt + 4'd1;
      default: begin
        if (invalid_cnt != 4'hf) invalid_next = invalid_cnt + 4'd1;
      end
    endcase

    end_next    = 1'b0;
    winner_next = 2'b00;
    if (p1_next == WIN_T) begin
      end_next    = 1'b1;
      winner_next = 2'b01;
    end else if (p2_next == WIN_T) begin
      end_next    = 1'b1;
      winner_next = 2'b10;
    end else if (round_next == ROUND_T) begin
      end_next = 1'b1;
      if (p1_next > p2_next)      winner_next = 2'b01;
      else if (p2_next > p1_next) winner_next = 2'b10;
      else                        winner_next = 2'b00;
    end

    case (winner_next)
      2'b01:   status_next = 8'd49;
      2'b10:   status_next = 8'd50;
      default: status_next = 8'd61;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      res_ready    <= 1'b0;
      p1_score     <= 4'd0;
      p2_score     <= 4'd0;
      round_cnt    <= 4'd0;
      invalid_cnt  <= 4'd0;
      match_done   <= 1'b0;
      match_winner <= 2'b00;
      done_pulse   <= 1'b0;
      status_char  <= 8'd0;
    end else begin
      done_pulse <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (new_match) begin
            state_reg    <= PLAY;
            res_ready    <= 1'b1;
            p1_score     <= 4'd0;
            p2_score     <= 4'd0;
            round_cnt    <= 4'd0;
            invalid_cnt  <= 4'd0;
            match_done   <= 1'b0;
            match_winner <= 2'b00;
            status_char  <= 8'd0;
          end
        end
        PLAY: begin
          // A restart request wins over any result offered in the same cycle
          if (new_match) begin
            p1_score    <= 4'd0;
            p2_score    <= 4'd0;
            round_cnt   <= 4'd0;
            invalid_cnt <= 4'd0;
          end else if (res_valid && res_ready) begin
            p1_score    <= p1_next;
            p2_score    <= p2_next;
            round_cnt   <= round_next;
            invalid_cnt <= invalid_next;
            if (end_next) begin
              state_reg    <= DONE;
              res_ready    <= 1'b0;
              match_done   <= 1'b1;
              done_pulse   <= 1'b1;
              match_winner <= winner_next;
              status_char  <= status_next;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rps_match_scorer.sv
// Directed bench for rps_match_scorer: a reference model pushes expected outputs per
// driven cycle into a scoreboard queue that is popped and checked after each clock edge.
module tb_rps_match_scorer;

  logic       clk = 1'b0;
  logic       rst, new_match, res_valid, res_ready;
  logic [7:0] res_code;
  logic [3:0] p1_score, p2_score, round_cnt, invalid_cnt;
  logic       match_done, done_pulse;
  logic [1:0] match_winner;
  logic [7:0] status_char;

  always #5 clk = ~clk;

  rps_match_scorer #(.WIN_TARGET(3), .ROUND_LIMIT(9)) dut (
    .clk(clk), .rst(rst), .new_match(new_match), .res_valid(res_valid),
    .res_ready(res_ready), .res_code(res_code), .p1_score(p1_score),
    .p2_score(p2_score), .round_cnt(round_cnt), .invalid_cnt(invalid_cnt),
    .match_done(match_done), .match_winner(match_winner),
    .done_pulse(done_pulse), .status_char(status_char)
  );

  typedef struct {
    logic [3:0] p1, p2, rc, ic;
    logic       done, pulse, rdy;
    logic [1:0] win;
    logic [7:0] st;
  } exp_t;

  exp_t exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state (0 idle, 1 play, 2 done)
  int         m_state = 0;
  logic [3:0] m_p1 = 0, m_p2 = 0, m_rc = 0, m_ic = 0;
  logic       m_done = 0, m_pulse = 0, m_rdy = 0;
  logic [1:0] m_win = 0;
  logic [7:0] m_st = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    m_p1 = 0; m_p2 = 0; m_rc = 0; m_ic = 0;
  endtask

  task automatic model_edge(input logic r, input logic nm, input logic rv, input logic [7:0] code);
    m_pulse = 0;
    if (r) begin
      model_clear();
      m_state = 0; m_done = 0; m_rdy = 0; m_win = 0; m_st = 0;
    end else if (m_state == 0 || m_state == 2) begin
      if (nm) begin
        model_clear();
        m_state = 1; m_rdy = 1; m_done = 0; m_win = 0; m_st = 0;
      end
    end else if (nm) begin
      model_clear();
    end else if (rv) begin
      if (code == 8'd49) begin m_p1++; m_rc++; end
      else if (code == 8'd50) begin m_p2++; m_rc++; end
      else if (code == 8'd0) m_rc++;
      else if (m_ic < 15) m_ic++;
      if (m_p1 == 3 || m_p2 == 3 || m_rc == 9) begin
        m_state = 2; m_rdy = 0; m_done = 1; m_pulse = 1;
        m_win = (m_p1 > m_p2) ? 2'b01 : (m_p2 > m_p1) ? 2'b10 : 2'b00;
        m_st  = (m_win == 2'b01) ? 8'd49 : (m_win == 2'b10) ? 8'd50 : 8'd61;
      end
    end
  endtask

  // Drive one cycle, push the model's prediction, then pop and compare after the edge
  task automatic step(input logic r, input logic nm, input logic rv, input logic [7:0] code);
    exp_t e;
    rst = r; new_match = nm; res_valid = rv; res_code = code;
    model_edge(r, nm, rv, code);
    e.p1 = m_p1; e.p2 = m_p2; e.rc = m_rc; e.ic = m_ic; e.done = m_done;
    e.pulse = m_pulse; e.rdy = m_rdy; e.win = m_win; e.st = m_st;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("p1_score", {4'd0, p1_score}, {4'd0, e.p1});
    chk("p2_score", {4'd0, p2_score}, {4'd0, e.p2});
    chk("round_cnt", {4'd0, round_cnt}, {4'd0, e.rc});
    chk("invalid_cnt", {4'd0, invalid_cnt}, {4'd0, e.ic});
    chk("match_done", {7'd0, match_done}, {7'd0, e.done});
    chk("done_pulse", {7'd0, done_pulse}, {7'd0, e.pulse});
    chk("res_ready", {7'd0, res_ready}, {7'd0, e.rdy});
    chk("match_winner", {6'd0, match_winner}, {6'd0, e.win});
    chk("status_char", status_char, e.st);
    $display("t=%0t rst=%0d nm=%0d vld=%0d code=%0d -> p1=%0d p2=%0d rc=%0d ic=%0d done=%0d pulse=%0d win=%0d st=%0d rdy=%0d",
             $time, r, nm, rv, code, p1_score, p2_score, round_cnt, invalid_cnt,
             match_done, done_pulse, match_winner, status_char, res_ready);
  endtask

  task automatic play_seq(input logic [7:0] codes[$]);
    foreach (codes[i]) step(0, 0, 1, codes[i]);
  endtask

  initial begin
    logic [7:0] seq[$];
    rst = 1; new_match = 0; res_valid = 0; res_code = 0;

    // Reset state, with a result offered that must be ignored in IDLE
    step(1, 0, 0, 8'd0);
    step(0, 0, 1, 8'd49);
    chk("idle_ignore_p1", {4'd0, p1_score}, 8'd0);

    // P1 wins three straight
    step(0, 1, 0, 8'd0);
    chk("ready_after_nm", {7'd0, res_ready}, 8'd1);
    seq = '{8'd49, 8'd49, 8'd49};
    play_seq(seq);
    chk("t1_winner", {6'd0, match_winner}, 8'd1);
    chk("t1_status", status_char, 8'd49);
    step(0, 0, 0, 8'd0);
    chk("t1_pulse_drop", {7'd0, done_pulse}, 8'd0);

    // Mixed results with invalid codes, P2 reaches target
    step(0, 1, 0, 8'd0);
    seq = '{8'd0, 8'd50, 8'd63, 8'd200, 8'd50, 8'd0, 8'd50};
    play_seq(seq);
    chk("t2_invalid", {4'd0, invalid_cnt}, 8'd2);
    chk("t2_rounds", {4'd0, round_cnt}, 8'd5);
    chk("t2_status", status_char, 8'd50);

    // Round limit with level scores -> draw
    step(0, 1, 0, 8'd0);
    seq = '{8'd49, 8'd50, 8'd0, 8'd49, 8'd50, 8'd0, 8'd0, 8'd0, 8'd0};
    play_seq(seq);
    chk("t3_rounds", {4'd0, round_cnt}, 8'd9);
    chk("t3_winner", {6'd0, match_winner}, 8'd0);
    chk("t3_status", status_char, 8'd61);

    // Restart mid-match beats a simultaneous result
    step(0, 1, 0, 8'd0);
    seq = '{8'd49, 8'd49};
    play_seq(seq);
    step(0, 1, 1, 8'd49);
    chk("t4_p1_cleared", {4'd0, p1_score}, 8'd0);
    chk("t4_no_done", {7'd0, match_done}, 8'd0);
    step(0, 0, 0, 8'd0);

    // Invalid counter saturation
    for (int i = 0; i < 17; i++) step(0, 0, 1, 8'd63);
    chk("t5_ic_sat", {4'd0, invalid_cnt}, 8'd15);

    // Reset mid-match, then results before new_match are ignored
    step(0, 1, 0, 8'd0);
    seq = '{8'd50, 8'd50};
    play_seq(seq);
    step(1, 0, 1, 8'd50);
    chk("t6_p2_reset", {4'd0, p2_score}, 8'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'd49);
    chk("t6_ignored", {4'd0, p1_score}, 8'd0);

    // Results held in DONE are ignored; new_match restarts
    step(0, 1, 0, 8'd0);
    seq = '{8'd49, 8'd49, 8'd49};
    play_seq(seq);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 8'd49);
    chk("t7_frozen", {4'd0, p1_score}, 8'd3);
    step(0, 1, 0, 8'd0);
    chk("t7_ready", {7'd0, res_ready}, 8'd1);
    chk("t7_cleared", {4'd0, p1_score}, 8'd0);
    step(0, 0, 1, 8'd50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rps_match_scorer.md
# rps_match_scorer

Match scorekeeper sitting directly downstream of the stone-paper-scissors round judge. It consumes one ASCII round-result byte per handshake, tallies per-player wins, rounds and invalid results, and declares a match winner in a first-to-target match with a round limit. Results are held for the display and readout logic until a new match is requested.

## Interface

Parameters:
- WIN_TARGET, 3, wins needed to take the match; legal 1..15
- ROUND_LIMIT, 9, counted rounds (wins plus ties) after which the match ends regardless; legal 1..15

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- new_match  in  1  level-sampled request to clear and start a match
- res_valid  in  1  round result present on res_code
- res_ready  out  1  block can accept a result this cycle
- res_code  in  8  judge output: 0 = tie, 49 = P1 wins, 50 = P2 wins, 63 = invalid; any other value is treated as invalid
- p1_score  out  4  P1 round wins this match
- p2_score  out  4  P2 round wins this match
- round_cnt  out  4  counted rounds (ties plus wins)
- invalid_cnt  out  4  invalid results this match, saturates at 15
- match_done  out  1  high while in DONE
- match_winner  out  2  00 none or draw, 01 P1, 10 P2; valid when match_done
- done_pulse  out  1  one-cycle strobe on entry to DONE
- status_char  out  8  49 P1 champion, 50 P2 champion, 61 ('=') draw, 0 otherwise

## Operation

- FSM states: IDLE, PLAY, DONE. Reset state is IDLE.
- IDLE: res_ready = 0. new_match = 1 -> PLAY, all counters cleared.
- PLAY: res_ready = 1. A transfer happens when res_valid and res_ready are both 1 on a clock edge.
  - 49 -> p1_score += 1, round_cnt += 1.
  - 50 -> p2_score += 1, round_cnt += 1.
  - 0 -> round_cnt += 1.
  - 63 or unlisted code -> invalid_cnt += 1, saturating at 15. No round is counted.
- End check uses post-update values of the same transfer:
  - If p1_score or p2_score reaches WIN_TARGET, go to DONE with that player as winner.
  - Otherwise, if round_cnt reaches ROUND_LIMIT, go to DONE with winner = higher score, or 00 if the scores are equal.
  - Only one score changes per transfer, so a double target is impossible.
- DONE: res_ready = 0. Counters, match_winner and status_char are frozen. new_match = 1 -> PLAY with counters and match_winner cleared.
- new_match = 1 in PLAY restarts the match: counters clear and the state stays PLAY. A res_valid in the same cycle is dropped, because new_match has priority.
- Counters are 4-bit unsigned. Parameter limits guarantee that scores and round_cnt never exceed 15.

## Timing

- Every output is registered. Reset values: res_ready 0, all counters 0, match_done 0, match_winner 00, done_pulse 0, status_char 0.
- rst is sampled on the clock edge. It overrides new_match and res_valid. Asserting it mid-match returns to IDLE with all outputs at reset values on the next cycle.
- Latency: counters reflect a transfer one cycle after the accepting edge.
- Final transfer at edge N:
  - At N+1, match_done = 1, done_pulse = 1, match_winner and status_char are valid, and res_ready = 0.
  - At N+2, done_pulse = 0.
- res_ready rises the cycle after new_match is sampled. Results presented while res_ready = 0 are ignored and never buffered. The upstream source must hold res_valid until it sees a transfer.
- new_match held high in DONE or PLAY keeps re-clearing every cycle. Transfers resume on the first cycle after new_match drops.
- Back-to-back transfers on consecutive cycles are supported at full rate.

## Test plan

- Reset then new_match, then results 49, 49, 49 on consecutive cycles -> p1_score 1, 2, 3 over successive cycles. match_done and done_pulse rise one cycle after the third transfer, match_winner 01, status_char 49, res_ready 0.
- Sequence 0, 50, 63, 200, 50, 0, 50 -> invalid_cnt 2, round_cnt 5, p2_score 3, match_winner 10, status_char 50.
- Default parameters, sequence 49, 50, 0, 49, 50, 0, 0, 0, 0 -> round limit hit at round_cnt 9 with 2 to 2. match_winner 00, status_char 61.
- In PLAY with p1_score 2, drive new_match and res_valid (code 49) in the same cycle -> all counters 0, state stays PLAY, no DONE entry.
- Assert rst for one cycle mid-match (p2_score 2) -> next cycle all outputs 0, res_ready 0. Results offered before the next new_match are ignored.
- In DONE, hold res_valid with code 49 for 5 cycles -> no counter changes and done_pulse stays low. Then pulse new_match -> counters clear and res_ready = 1 the following cycle.
